// File: rtl/tx_pkt_arb.sv
// tx_pkt_arb: frame-level arbiter between the ARP reply generator and the
// UDP/IP frame builder. It grants one whole frame at a time and forwards it
// combinationally. ARP has priority, but it can win only ARP_MAX times in a
// row while UDP is waiting. A fixed idle gap follows every frame.
module tx_pkt_arb #(
    parameter int IFG_CYC = 6,
    parameter int ARP_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] arp_data,
    input  logic        arp_sop,
    input  logic        arp_eop,
    input  logic        arp_vld,
    input  logic        arp_mod,
    output logic        arp_rdy,
    input  logic [15:0] udp_data,
    input  logic        udp_sop,
    input  logic        udp_eop,
    input  logic        udp_vld,
    input  logic        udp_mod,
    output logic        udp_rdy,
    output logic [15:0] dout,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_vld,
    output logic        dout_mod,
    input  logic        dout_rdy,
    output logic [1:0]  grant,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ARP, S_UDP, S_GAP} state_t;

    // A zero gap still needs a legal counter width, even though the counter is never used.
    localparam int GW = (IFG_CYC > 0) ? $clog2(IFG_CYC + 1) : 1;
    localparam int RW = $clog2(ARP_MAX + 1);
    localparam logic [GW-1:0] GAP_LAST = (IFG_CYC > 0) ? GW'(IFG_CYC - 1) : '0;
    localparam logic [RW-1:0] RUN_MAX  = RW'(ARP_MAX);
    localparam state_t        END_ST   = (IFG_CYC > 0) ? S_GAP : S_IDLE;

    state_t          state, state_nxt;
    logic [RW-1:0]   arp_run, arp_run_nxt;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
    logic [1:0]      drop_inc;
    logic [16:0]     drop_sum;
    logic            arp_req, udp_req, arp_orph, udp_orph;

    assign arp_req  = arp_vld & arp_sop;
    assign udp_req  = udp_vld & udp_sop;
    assign arp_orph = arp_vld & ~arp_sop;
    assign udp_orph = udp_vld & ~udp_sop;
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

    // State, starvation counter, gap counter and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            arp_run  <= '0;
            gap_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            arp_run  <= arp_run_nxt;
            gap_cnt  <= gap_cnt_nxt;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Arbitration, orphan draining, pass-through muxing and frame-end detection.
    always_comb begin
        state_nxt   = state;
        arp_run_nxt = arp_run;
        gap_cnt_nxt = gap_cnt;
        drop_inc    = 2'd0;
        arp_rdy     = 1'b0;
        udp_rdy     = 1'b0;
        dout        = '0;
        dout_sop    = 1'b0;
        dout_eop    = 1'b0;
        dout_vld    = 1'b0;
        dout_mod    = 1'b0;
        grant       = 2'b00;
        case (state)
            S_IDLE: begin
                // Words without sop seen here belong to no frame; discard them.
                arp_rdy  = arp_orph;
                udp_rdy  = udp_orph;
                drop_inc = 2'(arp_orph) + 2'(udp_orph);
                if (arp_req && (!udp_req || arp_run < RUN_MAX)) begin
                    state_nxt = S_ARP;
                    // The run only counts wins that made UDP wait. Under that
                    // condition arp_run < RUN_MAX, so it cannot overflow.
                    arp_run_nxt = udp_req ? arp_run + RW'(1) : '0;
                end else if (udp_req) begin
                    state_nxt   = S_UDP;
                    arp_run_nxt = '0;
                end
            end
            S_ARP: begin
                grant    = 2'b01;
                dout     = arp_data;
                dout_vld = arp_vld;
                dout_sop = arp_vld & arp_sop;
                dout_eop = arp_vld & arp_eop;
                dout_mod = arp_vld & arp_eop & arp_mod;
                arp_rdy  = dout_rdy;
                if (arp_vld && dout_rdy && arp_eop) state_nxt = END_ST;
            end
            S_UDP: begin
                grant    = 2'b10;
                dout     = udp_data;
                dout_vld = udp_vld;
                dout_sop = udp_vld & udp_sop;
                dout_eop = udp_vld & udp_eop;
                dout_mod = udp_vld & udp_eop & udp_mod;
                udp_rdy  = dout_rdy;
                if (udp_vld && dout_rdy && udp_eop) state_nxt = END_ST;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt   = S_IDLE;
                    gap_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
